ghost_mode_timer: RTL and testbench
===================================

Name: ghost_mode_timer

Overview:
Downstream consumer of the game's divided clock. Treats the divider output as a 1 Hz tick and sequences ghost behaviour: the scatter/chase schedule, the frightened override after a power pellet, and the frightened-ending warning. It also drives the speed word for the ghost-movement clock divider.

Parameters:
SCATTER_LONG, 7, length of scatter phases 0 and 2, in ticks
SCATTER_SHORT, 5, length of scatter phases 4 and 6, in ticks
CHASE_LEN, 20, length of chase phases 1, 3 and 5, in ticks
FRIGHT_LEN, 6, frightened duration in ticks
FLASH_LEN, 2, frightEnding asserted while ticks remaining <= FLASH_LEN
NORMAL_SPEED, 75, speed word outside frightened
FRIGHT_SPEED, 50, speed word during frightened

Ports:
inClock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
tickIn  input  1  divided clock level from the divider, same clock domain
pelletEaten  input  1  one-cycle pulse: power pellet consumed
pause  input  1  high freezes all timing (tick and pellet both ignored)
mode  output  2  0 = SCATTER, 1 = CHASE, 2 = FRIGHTENED; 3 is never driven
modeChanged  output  1  one-cycle pulse when mode changes (ghosts reverse)
frightEnding  output  1  high during the final FLASH_LEN frightened ticks
speed  output  32  speed word for the ghost clock divider

Behaviour:
- Reset values: mode=0, modeChanged=0, frightEnding=0, speed=NORMAL_SPEED, phase=0, phaseCount=SCATTER_LONG, frightened=0, frightCount=0, tickIn_q=0.
- Tick detection: tick = tickIn & ~tickIn_q, where tickIn_q is tickIn registered. No synchronizer is used because both are in the same domain. Exactly one tick per rising edge of tickIn.
- All outputs are registered. A tick seen at edge N updates the outputs after edge N.
- pause=1: tick and pelletEaten are discarded and all state holds. tickIn_q still updates, so an edge that occurs during pause is lost and is not replayed.
- Schedule: phase 0..7. Phase lengths are SL, C, SL, C, SS, C, SS, infinite, where SL=SCATTER_LONG, SS=SCATTER_SHORT, C=CHASE_LEN. Even phases are scatter; odd phases are chase.
- Tick while not frightened and phase<7:
  - phaseCount==1: phase++, phaseCount loads the next length, modeChanged=1.
  - otherwise: phaseCount--.
  - Phase 7 never decrements and never ends.
- pelletEaten (not paused):
  - frightened=1 and frightCount=FRIGHT_LEN.
  - The schedule state is frozen, not reset.
  - modeChanged=1 only if the previous mode was not FRIGHTENED; a re-eat during frightened refreshes the count without a pulse.
- Tick while frightened:
  - frightCount==1: frightened=0, mode returns to the frozen phase's mode, modeChanged=1.
  - otherwise: frightCount--.
- Simultaneous tick and pelletEaten: the pellet wins. frightCount=FRIGHT_LEN and the tick is dropped for both counters.
- Derived outputs:
  - frightEnding = frightened & (frightCount <= FLASH_LEN), registered alongside the state.
  - mode = frightened ? 2 : phase[0].
  - speed = frightened ? FRIGHT_SPEED : NORMAL_SPEED; it changes on the same edge as mode.
- modeChanged is never asserted on the cycle after reset release and never lasts more than one cycle.
- Reset mid-phase or mid-fright: outputs return to their reset values asynchronously, and the schedule restarts at phase 0 after release.

Test Plan:
- Reset, then 7 ticks -> mode=0 through tick 6. On tick 7: mode=1, one modeChanged pulse, phaseCount=20.
- Run 7+20+7+20+5+20+5 ticks -> mode sequence 0,1,0,1,0,1,0,1 with 7 modeChanged pulses. A further 100 ticks -> mode stays 1 with no pulses.
- In phase 1 after 3 ticks, pulse pelletEaten -> mode=2, speed=50, modeChanged pulse. Tick 5 of fright -> frightEnding=1. Tick 6 -> mode=1, speed=75, pulse; then 17 more ticks are needed to reach phase 2.
- Frightened with frightCount=2, pulse pelletEaten -> no modeChanged, frightEnding=0, 6 more ticks needed to exit. Pellet and tick on the same edge -> frightCount=6.
- pause=1 across 3 tickIn edges and a pelletEaten -> no state change. Holding tickIn high for many cycles -> only one tick counted.
- Assert reset asynchronously mid-fright, between clock edges -> mode=0, speed=75, frightEnding=0 immediately. After release, 7 ticks to the first CHASE.

Source files
------------

// File: rtl/ghost_mode_timer.sv
// Ghost behaviour sequencer driven by the 1 Hz divided clock: scatter/chase
// schedule, frightened override with end-of-fright warning, and ghost speed word.
module ghost_mode_timer #(
    parameter int unsigned SCATTER_LONG  = 7,
    parameter int unsigned SCATTER_SHORT = 5,
    parameter int unsigned CHASE_LEN     = 20,
    parameter int unsigned FRIGHT_LEN    = 6,
    parameter int unsigned FLASH_LEN     = 2,
    parameter int unsigned NORMAL_SPEED  = 75,
    parameter int unsigned FRIGHT_SPEED  = 50
) (
    input  logic        inClock,
    input  logic        reset,
    input  logic        tickIn,
    input  logic        pelletEaten,
    input  logic        pause,
    output logic [1:0]  mode,
    output logic        modeChanged,
    output logic        frightEnding,
    output logic [31:0] speed
);

    typedef enum logic [2:0] {
        PH_SCATTER_0,
        PH_CHASE_1,
        PH_SCATTER_2,
        PH_CHASE_3,
        PH_SCATTER_4,
        PH_CHASE_5,
        PH_SCATTER_6,
        PH_CHASE_FINAL
    } phase_t;

    phase_t      phase, phase_n;
    logic [31:0] phase_count, phase_count_n;
    logic        frightened, frightened_n;
    logic [31:0] fright_count, fright_count_n;
    logic        tick_in_q;
    logic        tick, pellet;
    logic [1:0]  mode_n;
    logic        mode_changed_n;
    logic        fright_ending_n;
    logic [31:0] speed_n;

    function automatic logic [31:0] phase_len(input phase_t p);
        case (p)
            PH_SCATTER_0, PH_SCATTER_2:          return SCATTER_LONG;
            PH_SCATTER_4, PH_SCATTER_6:          return SCATTER_SHORT;
            PH_CHASE_1, PH_CHASE_3, PH_CHASE_5:  return CHASE_LEN;
            default:                             return 32'd0;
        endcase
    endfunction

    // Pause discards events, but the edge detector keeps tracking so paused edges are lost.
    assign tick   = tickIn & ~tick_in_q & ~pause;
    assign pellet = pelletEaten & ~pause;

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            tick_in_q    <= 1'b0;
            phase        <= PH_SCATTER_0;
            phase_count  <= SCATTER_LONG;
            frightened   <= 1'b0;
            fright_count <= 32'd0;
            mode         <= 2'd0;
            modeChanged  <= 1'b0;
            frightEnding <= 1'b0;
            speed        <= NORMAL_SPEED;
        end else begin
            tick_in_q    <= tickIn;
            phase        <= phase_n;
            phase_count  <= phase_count_n;
            frightened   <= frightened_n;
            fright_count <= fright_count_n;
            mode         <= mode_n;
            modeChanged  <= mode_changed_n;
            frightEnding <= fright_ending_n;
            speed        <= speed_n;
        end
    end

    always_comb begin
        phase_n        = phase;
        phase_count_n  = phase_count;
        frightened_n   = frightened;
        fright_count_n = fright_count;
        mode_changed_n = 1'b0;

        // A pellet beats a coincident tick; the schedule stays frozen while frightened.
        if (pellet) begin
            frightened_n   = 1'b1;
            fright_count_n = FRIGHT_LEN;
            mode_changed_n = ~frightened;
        end else if (tick) begin
            if (frightened) begin
                if (fright_count == 32'd1) begin
                    frightened_n   = 1'b0;
                    fright_count_n = 32'd0;
                    mode_changed_n = 1'b1;
                end else begin
                    fright_count_n = fright_count - 32'd1;
                end
            end else if (phase != PH_CHASE_FINAL) begin
                if (phase_count == 32'd1) begin
                    phase_n        = phase_t'(phase + 3'd1);
                    phase_count_n  = phase_len(phase_n);
                    mode_changed_n = 1'b1;
                end else begin
                    phase_count_n = phase_count - 32'd1;
                end
            end
        end

        mode_n          = frightened_n ? 2'd2 : {1'b0, phase_n[0]};
        fright_ending_n = frightened_n && (fright_count_n <= FLASH_LEN);
        speed_n         = frightened_n ? FRIGHT_SPEED : NORMAL_SPEED;
    end

endmodule

// File: tb/tb_ghost_mode_timer.sv
// Bench for ghost_mode_timer: a table of operations with hand-derived expected
// outputs, routed through a scoreboard queue, plus reset corner sequences.
module tb_ghost_mode_timer;

    logic        inClock = 1'b0;
    logic        reset;
    logic        tickIn;
    logic        pelletEaten;
    logic        pause;
    logic [1:0]  mode;
    logic        modeChanged;
    logic        frightEnding;
    logic [31:0] speed;

    ghost_mode_timer dut (
        .inClock      (inClock),
        .reset        (reset),
        .tickIn       (tickIn),
        .pelletEaten  (pelletEaten),
        .pause        (pause),
        .mode         (mode),
        .modeChanged  (modeChanged),
        .frightEnding (frightEnding),
        .speed        (speed)
    );

    always #5 inClock = ~inClock;

    typedef struct {
        int          n_ticks;
        int          high_cycles;
        bit          pellet;
        bit          combo;
        bit          paused;
        logic [1:0]  exp_mode;
        int          exp_pulses;
        logic        exp_fe;
        logic [31:0] exp_speed;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[33];
    int   pulse_cnt = 0;
    int   op_pulse_start = 0;
    int   total = 0;
    int   passed = 0;

    // Count modeChanged pulses mid-cycle; a stretched pulse counts more than once.
    always @(negedge inClock) begin
        if (modeChanged === 1'b1) pulse_cnt++;
    end

    function automatic vec_t mkv(int n, int hold, bit pel, bit combo, bit pz,
                                 logic [1:0] m, int p, logic fe, logic [31:0] sp);
        vec_t v;
        v.n_ticks = n; v.high_cycles = hold; v.pellet = pel; v.combo = combo;
        v.paused = pz; v.exp_mode = m; v.exp_pulses = p; v.exp_fe = fe;
        v.exp_speed = sp;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic expectNext(input vec_t v);
        sb.push_back(v);
        op_pulse_start = pulse_cnt;
    endtask

    task automatic applyStimulus(input vec_t v);
        expectNext(v);
        if (v.paused) begin
            @(negedge inClock); pause = 1'b1;
        end
        if (v.pellet) begin
            @(negedge inClock); pelletEaten = 1'b1;
            @(negedge inClock); pelletEaten = 1'b0;
        end
        for (int k = 0; k < v.n_ticks; k++) begin
            @(negedge inClock);
            tickIn = 1'b1;
            if (v.combo && k == 0) pelletEaten = 1'b1;
            for (int h = 1; h < v.high_cycles; h++) begin
                @(negedge inClock); pelletEaten = 1'b0;
            end
            @(negedge inClock);
            tickIn = 1'b0;
            pelletEaten = 1'b0;
        end
        if (v.paused) begin
            @(negedge inClock); pause = 1'b0;
        end
        @(negedge inClock);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            total++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        checkVal({tag, ".mode"}, {30'd0, mode}, {30'd0, e.exp_mode});
        checkVal({tag, ".pulses"}, pulse_cnt - op_pulse_start, e.exp_pulses);
        checkVal({tag, ".frightEnding"}, {31'd0, frightEnding}, {31'd0, e.exp_fe});
        checkVal({tag, ".speed"}, speed, e.exp_speed);
    endtask

    initial begin
        // n, hold, pellet, combo, pause -> mode, pulses, frightEnding, speed
        vecs[0]  = mkv(6,   1,  0, 0, 0, 2'd0, 0, 1'b0, 32'd75);
        vecs[1]  = mkv(1,   1,  0, 0, 0, 2'd1, 1, 1'b0, 32'd75);
        vecs[2]  = mkv(3,   1,  0, 0, 0, 2'd1, 0, 1'b0, 32'd75);
        vecs[3]  = mkv(0,   1,  1, 0, 0, 2'd2, 1, 1'b0, 32'd50);
        vecs[4]  = mkv(3,   1,  0, 0, 0, 2'd2, 0, 1'b0, 32'd50);
        vecs[5]  = mkv(1,   1,  0, 0, 0, 2'd2, 0, 1'b1, 32'd50);
        vecs[6]  = mkv(1,   1,  0, 0, 0, 2'd2, 0, 1'b1, 32'd50);
        vecs[7]  = mkv(1,   1,  0, 0, 0, 2'd1, 1, 1'b0, 32'd75);
        vecs[8]  = mkv(16,  1,  0, 0, 0, 2'd1, 0, 1'b0, 32'd75);
        vecs[9]  = mkv(1,   1,  0, 0, 0, 2'd0, 1, 1'b0, 32'd75);
        vecs[10] = mkv(0,   1,  1, 0, 0, 2'd2, 1, 1'b0, 32'd50);
        vecs[11] = mkv(4,   1,  0, 0, 0, 2'd2, 0, 1'b1, 32'd50);
        vecs[12] = mkv(0,   1,  1, 0, 0, 2'd2, 0, 1'b0, 32'd50);
        vecs[13] = mkv(5,   1,  0, 0, 0, 2'd2, 0, 1'b1, 32'd50);
        vecs[14] = mkv(1,   1,  0, 0, 0, 2'd0, 1, 1'b0, 32'd75);
        vecs[15] = mkv(0,   1,  1, 0, 0, 2'd2, 1, 1'b0, 32'd50);
        vecs[16] = mkv(2,   1,  0, 0, 0, 2'd2, 0, 1'b0, 32'd50);
        vecs[17] = mkv(1,   1,  0, 1, 0, 2'd2, 0, 1'b0, 32'd50);
        vecs[18] = mkv(5,   1,  0, 0, 0, 2'd2, 0, 1'b1, 32'd50);
        vecs[19] = mkv(1,   1,  0, 0, 0, 2'd0, 1, 1'b0, 32'd75);
        vecs[20] = mkv(3,   1,  1, 0, 1, 2'd0, 0, 1'b0, 32'd75);
        vecs[21] = mkv(6,   1,  0, 0, 0, 2'd0, 0, 1'b0, 32'd75);
        vecs[22] = mkv(1,   1,  0, 0, 0, 2'd1, 1, 1'b0, 32'd75);
        vecs[23] = mkv(1,   12, 0, 0, 0, 2'd1, 0, 1'b0, 32'd75);
        vecs[24] = mkv(18,  1,  0, 0, 0, 2'd1, 0, 1'b0, 32'd75);
        vecs[25] = mkv(1,   1,  0, 0, 0, 2'd0, 1, 1'b0, 32'd75);
        vecs[26] = mkv(4,   1,  0, 0, 0, 2'd0, 0, 1'b0, 32'd75);
        vecs[27] = mkv(1,   1,  0, 0, 0, 2'd1, 1, 1'b0, 32'd75);
        vecs[28] = mkv(19,  1,  0, 0, 0, 2'd1, 0, 1'b0, 32'd75);
        vecs[29] = mkv(1,   1,  0, 0, 0, 2'd0, 1, 1'b0, 32'd75);
        vecs[30] = mkv(4,   1,  0, 0, 0, 2'd0, 0, 1'b0, 32'd75);
        vecs[31] = mkv(1,   1,  0, 0, 0, 2'd1, 1, 1'b0, 32'd75);
        vecs[32] = mkv(100, 1,  0, 0, 0, 2'd1, 0, 1'b0, 32'd75);

        reset = 1'b1;
        tickIn = 1'b0;
        pelletEaten = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge inClock);
        #1;
        expectNext(mkv(0, 1, 0, 0, 0, 2'd0, 0, 1'b0, 32'd75));
        checkOutput("reset");
        @(negedge inClock);
        reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Asynchronous reset between clock edges while in the flash window.
        reset = 1'b1;
        @(negedge inClock);
        reset = 1'b0;
        applyStimulus(mkv(4, 1, 1, 0, 0, 2'd2, 1, 1'b1, 32'd50));
        checkOutput("preReset");
        expectNext(mkv(0, 1, 0, 0, 0, 2'd0, 0, 1'b0, 32'd75));
        @(negedge inClock);
        #3 reset = 1'b1;
        #1;
        checkOutput("asyncReset");
        @(negedge inClock);
        reset = 1'b0;
        applyStimulus(mkv(0, 1, 0, 0, 0, 2'd0, 0, 1'b0, 32'd75));
        checkOutput("postRelease");
        applyStimulus(mkv(6, 1, 0, 0, 0, 2'd0, 0, 1'b0, 32'd75));
        checkOutput("restart6");
        applyStimulus(mkv(1, 1, 0, 0, 0, 2'd1, 1, 1'b0, 32'd75));
        checkOutput("restartChase");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
